// File: rtl/seq_ctrl_pkg.sv
// Shared types and defaults for the serial pattern-detection controller.
// The optional SEQ_CTRL_OVERLAP_EN macro is consumed by seq_match.
package seq_ctrl_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int CNT_W_DEF = 8;
    localparam int LEN_W_DEF = $clog2(PAT_W_DEF) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    function automatic int seq_len_w(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

endpackage

// File: rtl/seq_match.sv
// Serial bit history, valid-bit counter and pattern comparator with a registered hit.
// Define SEQ_CTRL_OVERLAP_EN to let consecutive occurrences share bits.
module seq_match
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic             din_i,
    input  logic [PAT_W-1:0] pat_i,
    input  logic [LEN_W-1:0] len_i,
    output logic             hit_o,
    output logic             hit_now_o
);

    localparam int VW = LEN_W + 1;

`ifdef SEQ_CTRL_OVERLAP_EN
    localparam bit OVERLAP = 1'b1;
`else
    localparam bit OVERLAP = 1'b0;
`endif

    logic [PAT_W-1:0] hist_q, hist_d, mask;
    logic [LEN_W-1:0] vld_q, vld_d;
    logic             hit_q;

    // Newest bit lands in bit 0, so bit len-1 holds the oldest compared bit.
    always_comb begin
        hist_d    = (hist_q << 1) | PAT_W'(din_i);
        mask      = ~({PAT_W{1'b1}} << len_i);
        hit_now_o = en_i
                 && ((VW'(vld_q) + VW'(1)) >= VW'(len_i))
                 && (((hist_d ^ pat_i) & mask) == '0);
        vld_d     = (vld_q < len_i) ? vld_q + 1'b1 : vld_q;
        if (hit_now_o && !OVERLAP) begin
            vld_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            hist_q <= '0;
            vld_q  <= '0;
            hit_q  <= 1'b0;
        end else begin
            hit_q <= hit_now_o;
            if (en_i) begin
                hist_q <= hist_d;
                vld_q  <= vld_d;
            end
        end
    end

    assign hit_o = hit_q;

endmodule

// File: rtl/seq_ctrl.sv
// Run controller: arms a detection run, counts matches up to a target, and reports done/err.
// Overlapping detection is selected in seq_match by SEQ_CTRL_OVERLAP_EN.
module seq_ctrl
    import seq_ctrl_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [PAT_W-1:0]       cfg_pat,
    input  logic [$clog2(PAT_W):0] cfg_len,
    input  logic [CNT_W-1:0]       cfg_target,
    input  logic                   din,
    output logic                   busy,
    output logic                   match,
    output logic [CNT_W-1:0]       match_cnt,
    output logic                   done,
    output logic                   err
);

    localparam int LEN_W = seq_len_w(PAT_W);

    state_e           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [LEN_W-1:0] len_q;
    logic [CNT_W-1:0] tgt_q, cnt_q;
    logic             busy_q, done_q, err_q;
    logic             cfg_ok, arm, shift_en, hit, hit_now;

    assign cfg_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(PAT_W)) && (cfg_target != '0);
    assign arm    = (state_q == S_IDLE) && start && cfg_ok;
    // Sampling stops once the target is reached so the count can never pass it.
    assign shift_en = (state_q == S_RUN) && !abort && (cnt_q != tgt_q);

    seq_match #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_match (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (arm),
        .en_i      (shift_en),
        .din_i     (din),
        .pat_i     (pat_q),
        .len_i     (len_q),
        .hit_o     (hit),
        .hit_now_o (hit_now)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            pat_q   <= cfg_pat;
                            len_q   <= cfg_len;
                            tgt_q   <= cfg_target;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_RUN;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end else if (cnt_q == tgt_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else if (hit_now) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign match     = hit;
    assign match_cnt = cnt_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_seq_ctrl.sv
// Directed bench for seq_ctrl with a match-count scoreboard; honours SEQ_CTRL_OVERLAP_EN.
module tb_seq_ctrl;

    localparam int PAT_W = 8;
    localparam int CNT_W = 8;

`ifdef SEQ_CTRL_OVERLAP_EN
    localparam bit OVL = 1'b1;
`else
    localparam bit OVL = 1'b0;
`endif

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   start = 1'b0;
    logic                   abort = 1'b0;
    logic [PAT_W-1:0]       cfg_pat = '0;
    logic [$clog2(PAT_W):0] cfg_len = '0;
    logic [CNT_W-1:0]       cfg_target = '0;
    logic                   din = 1'b0;
    logic                   busy, match, done, err;
    logic [CNT_W-1:0]       match_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;
    int sb_q[$];

    seq_ctrl #(.PAT_W(PAT_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .cfg_pat    (cfg_pat),
        .cfg_len    (cfg_len),
        .cfg_target (cfg_target),
        .din        (din),
        .busy       (busy),
        .match      (match),
        .match_cnt  (match_cnt),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [PAT_W-1:0] pat, input int len, input int tgt);
        cfg_pat    = pat;
        cfg_len    = len[$clog2(PAT_W):0];
        cfg_target = tgt[CNT_W-1:0];
        start      = 1'b1;
        tick();
        start   = 1'b0;
        exp_cnt = 0;
        chk("start_busy", busy, 1);
        chk("start_cnt", match_cnt, 0);
    endtask

    task automatic drive_bit(input logic b, input logic exp_m, input string tag);
        din = b;
        if (exp_m) begin
            exp_cnt++;
            sb_q.push_back(exp_cnt);
        end
        tick();
        chk({tag, "_match"}, match, exp_m);
    endtask

    // Scoreboard: every match pulse must correspond to a queued expected count.
    always @(negedge clk) begin
        if (match === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_match", 1, 0);
            end else begin
                chk("sb_cnt", match_cnt, sb_q.pop_front());
            end
        end
    end

    initial begin
        // Reset state
        tick();
        tick();
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_match", match, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", match_cnt, 0);

        // Basic 5-bit pattern, target 1
        do_start(8'b0000_0111, 5, 1);
        drive_bit(1'b0, 1'b0, "p5_b0");
        drive_bit(1'b0, 1'b0, "p5_b1");
        drive_bit(1'b1, 1'b0, "p5_b2");
        drive_bit(1'b1, 1'b0, "p5_b3");
        drive_bit(1'b1, 1'b1, "p5_b4");
        chk("p5_busy_at_match", busy, 1);
        chk("p5_done_at_match", done, 0);
        din = 1'b0;
        tick();
        chk("p5_done", done, 1);
        chk("p5_busy_in_done", busy, 0);
        chk("p5_match_in_done", match, 0);
        tick();
        chk("p5_done_cleared", done, 0);
        chk("p5_cnt_held", match_cnt, 1);

        // Overlap behaviour on 101 within 10101
        do_start(8'b0000_0101, 3, 3);
        drive_bit(1'b1, 1'b0, "ov_b0");
        drive_bit(1'b0, 1'b0, "ov_b1");
        drive_bit(1'b1, 1'b1, "ov_b2");
        drive_bit(1'b0, 1'b0, "ov_b3");
        drive_bit(1'b1, OVL, "ov_b4");
        chk("ov_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ov_abort_busy", busy, 0);
        chk("ov_abort_done", done, 0);
        chk("ov_cnt", match_cnt, OVL ? 2 : 1);

        // Illegal configurations: len=0, target=0, len>PAT_W
        cfg_len = 0; cfg_target = 1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_len0_err", err, 1);
        chk("ill_len0_busy", busy, 0);
        chk("ill_len0_cnt", match_cnt, OVL ? 2 : 1);
        tick();
        chk("ill_err_pulse", err, 0);
        cfg_len = 3; cfg_target = 0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_tgt0_err", err, 1);
        chk("ill_tgt0_busy", busy, 0);
        tick();
        cfg_len = 9; cfg_target = 1; start = 1'b1;
        tick();
        start = 1'b0;
        chk("ill_len9_err", err, 1);
        chk("ill_len9_busy", busy, 0);
        tick();
        chk("ill_busy_after", busy, 0);
        chk("ill_cnt_after", match_cnt, OVL ? 2 : 1);

        // Abort coinciding with the final match
        do_start(8'b0000_0011, 2, 2);
        drive_bit(1'b1, 1'b0, "ab_b0");
        drive_bit(1'b1, 1'b1, "ab_b1");
        drive_bit(1'b0, 1'b0, "ab_b2");
        drive_bit(1'b1, 1'b0, "ab_b3");
        din = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_match", match, 0);
        chk("ab_done", done, 0);
        chk("ab_busy", busy, 0);
        chk("ab_cnt", match_cnt, 1);
        tick();
        chk("ab_done_late", done, 0);
        chk("ab_match_late", match, 0);

        // Reset mid-run with match_cnt=2, then a normal run with len=1 boundary
        do_start(8'b0000_0001, 1, 5);
        drive_bit(1'b1, 1'b1, "rr_b0");
        drive_bit(1'b1, 1'b1, "rr_b1");
        chk("rr_cnt_pre", match_cnt, 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rr_busy", busy, 0);
        chk("rr_match", match, 0);
        chk("rr_done", done, 0);
        chk("rr_err", err, 0);
        chk("rr_cnt", match_cnt, 0);
        tick();
        chk("rr_no_done", done, 0);
        do_start(8'b0000_0010, 2, 1);
        drive_bit(1'b1, 1'b0, "rs_b0");
        drive_bit(1'b0, 1'b1, "rs_b1");
        tick();
        chk("rs_done", done, 1);
        chk("rs_busy", busy, 0);
        tick();
        chk("rs_cnt", match_cnt, 1);

        // Full-width pattern, len=PAT_W
        do_start(8'hA5, 8, 1);
        for (int i = 7; i >= 0; i--) begin
            logic [7:0] p;
            p = 8'hA5;
            drive_bit(p[i], (i == 0), "fw");
        end
        din = 1'b0;
        tick();
        chk("fw_done", done, 1);
        tick();
        chk("fw_cnt", match_cnt, 1);
        chk("fw_busy", busy, 0);

        chk("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_ctrl.md
SEQ_CTRL -- requirements
Module: seq_ctrl

Interface
REQ-001 SHALL have parameter PAT_W, default 8: maximum pattern length in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of the match counter and the target.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port start  input  1  request to arm a detection run; sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  terminates a run without done.
REQ-007 SHALL have port cfg_pat  input  PAT_W  pattern; bit cfg_len-1 is the first bit expected.
REQ-008 SHALL have port cfg_len  input  $clog2(PAT_W)+1  pattern length; legal range 1..PAT_W.
REQ-009 SHALL have port cfg_target  input  CNT_W  number of matches that ends the run; legal range 1..2^CNT_W-1.
REQ-010 SHALL have port din  input  1  serial data, one bit per clock.
REQ-011 SHALL have port busy  output  1  high while a run is in progress.
REQ-012 SHALL have port match  output  1  one-cycle pulse per detected occurrence.
REQ-013 SHALL have port match_cnt  output  CNT_W  matches in the current or last run.
REQ-014 SHALL have port done  output  1  one-cycle pulse when match_cnt reaches the target.
REQ-015 SHALL have port err  output  1  one-cycle pulse when start is given with an illegal configuration.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE + start + legal cfg: next cycle SHALL latch cfg_pat/len/target, clear match_cnt and bit history, and enter RUN; busy=1 from that cycle.
REQ-018 IDLE + start + illegal cfg (cfg_len=0, cfg_len>PAT_W or cfg_target=0): err SHALL pulse the next cycle, the FSM SHALL stay in IDLE, and match_cnt SHALL be unchanged.
REQ-019 In RUN, din SHALL be shifted into history every cycle; cfg inputs and start SHALL be ignored.
REQ-020 A match SHALL occur when at least cfg_len bits are valid since the last history clear and the last cfg_len bits equal the latched cfg_pat[cfg_len-1:0], oldest bit compared to the MSB.
REQ-021 match SHALL pulse in the cycle after the completing bit is sampled, and match_cnt SHALL increment in that same cycle.
REQ-022 When the increment makes match_cnt equal the target, the FSM SHALL enter DONE: done=1 and busy=0 for one cycle, then IDLE; din is not sampled in DONE.
REQ-023 abort in RUN SHALL return the FSM to IDLE next cycle with no done pulse; abort SHALL win over a simultaneous final match (match and done not asserted, match_cnt not incremented).
REQ-024 match_cnt SHALL hold its value in IDLE until the next legal start.
REQ-025 match_cnt SHALL never wrap, because the run ends at the target, which is at most 2^CNT_W-1.

Reset
REQ-026 rst SHALL force IDLE with busy=0, match=0, done=0, err=0, match_cnt=0, and history and valid count cleared.
REQ-027 rst SHALL take priority over all other inputs, including mid-run, and no done pulse SHALL follow.

Configuration
REQ-028 With SEQ_CTRL_OVERLAP_EN defined, history SHALL be retained after a match, so occurrences may share bits.
REQ-029 Without SEQ_CTRL_OVERLAP_EN, the valid-bit count SHALL clear on each match, so the next match needs cfg_len fresh bits (non-overlapping).

Structure
REQ-030 Package seq_ctrl_pkg SHALL hold the state enum, the PAT_W/CNT_W defaults and the cfg_len width constant.
REQ-031 Sub-module seq_match SHALL hold the shift history, the valid counter and the comparator, and SHALL produce a registered hit pulse; seq_ctrl holds the FSM and counter.

Verification
REQ-032 Pattern match: cfg_pat=5'b00111, len=5, target=1, din 0,0,1,1,1 -> one match one cycle after the 5th bit, done the following cycle, match_cnt=1.
REQ-033 Overlap: cfg_pat=3'b101, len=3, target=3, din 1,0,1,0,1 -> 2 matches with SEQ_CTRL_OVERLAP_EN, 1 match without it; busy remains 1 in both cases.
REQ-034 Illegal configuration: start with len=0, then start with target=0 -> err pulses twice, busy never 1.
REQ-035 Abort: abort in the same cycle as the final (target) match -> no done, match_cnt = target-1, IDLE next cycle.
REQ-036 Reset mid-run: rst with match_cnt=2 -> all outputs 0 next cycle; a following legal start runs normally.
